// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-to-one inst/data arbiter onto a single SRAM-like port, one outstanding transaction
// Optional ARB_ROUND_ROBIN_EN: alternate grants on ties; otherwise data always wins ties.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q;
  logic                grant_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                pick_data;
  logic                accept;
  logic                resp;
  logic                wr_d;
  logic [1:0]          size_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W/8-1:0] wstrb_d;
  logic [DATA_W-1:0]   wdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  always_comb begin
    pick_data = data_req;
    if (inst_req && data_req) pick_data = ~last_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     last_q <= 1'b0;
    else if (accept) last_q <= pick_data;
  end
`else
  always_comb pick_data = data_req;
`endif

  // Gating with resetn keeps addr_ok low while reset is held, not just after it.
  assign accept       = resetn && (state_q == IDLE) && (inst_req || data_req);
  assign inst_addr_ok = accept && !pick_data;
  assign data_addr_ok = accept &&  pick_data;

  assign wr_d    = pick_data ? data_wr    : inst_wr;
  assign size_d  = pick_data ? data_size  : inst_size;
  assign addr_d  = pick_data ? data_addr  : inst_addr;
  assign wstrb_d = pick_data ? data_wstrb : inst_wstrb;
  assign wdata_d = pick_data ? data_wdata : inst_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= ADDR;
          grant_q <= pick_data;
          wr_q    <= wr_d;
          size_q  <= size_d;
          addr_q  <= addr_d;
          wstrb_q <= wstrb_d;
          wdata_q <= wdata_d;
        end
        ADDR:    if (mem_addr_ok) state_q <= DATA;
        DATA:    if (mem_data_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q == ADDR);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

  // Stray mem_data_ok outside DATA never reaches a requester.
  assign resp         = (state_q == DATA) && mem_data_ok;
  assign inst_data_ok = resp && !grant_q;
  assign data_data_ok = resp &&  grant_q;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - table-driven and hand-sequenced bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ir, iw;
    logic [1:0]  isz;
    logic [31:0] ia, id;
    logic [3:0]  is;
    logic        dr, dw;
    logic [1:0]  dsz;
    logic [31:0] da, dd;
    logic [3:0]  ds;
    int          stall;
    logic [31:0] rdata;
    logic        gnt;
  } vec_t;

  typedef struct {
    logic        gnt, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endfunction

  function automatic vec_t mk(logic ir, logic iw, logic [1:0] isz, logic [31:0] ia, logic [3:0] is,
                              logic [31:0] id, logic dr, logic dw, logic [1:0] dsz, logic [31:0] da,
                              logic [3:0] ds, logic [31:0] dd, int stall, logic [31:0] rdata, logic gnt);
    vec_t v;
    v.ir = ir; v.iw = iw; v.isz = isz; v.ia = ia; v.is = is; v.id = id;
    v.dr = dr; v.dw = dw; v.dsz = dsz; v.da = da; v.ds = ds; v.dd = dd;
    v.stall = stall; v.rdata = rdata; v.gnt = gnt;
    return v;
  endfunction

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    exp_t f;
    @(posedge clk); #1;
    inst_req = v.ir; inst_wr = v.iw; inst_size = v.isz; inst_addr = v.ia; inst_wstrb = v.is; inst_wdata = v.id;
    data_req = v.dr; data_wr = v.dw; data_size = v.dsz; data_addr = v.da; data_wstrb = v.ds; data_wdata = v.dd;
    @(negedge clk);
    chk("idle_mem_req", mem_req, 0);
    chk("inst_addr_ok", inst_addr_ok, !v.gnt);
    chk("data_addr_ok", data_addr_ok, v.gnt);
    e.gnt = v.gnt;
    e.wr = v.gnt ? v.dw : v.iw;       e.size  = v.gnt ? v.dsz : v.isz;
    e.addr = v.gnt ? v.da : v.ia;     e.wstrb = v.gnt ? v.ds : v.is;
    e.wdata = v.gnt ? v.dd : v.id;    e.rdata = v.rdata;
    sb.push_back(e);
    // Loser keeps requesting through ADDR and DATA and must not be accepted.
    for (int c = 0; c <= v.stall; c++) begin
      @(posedge clk); #1;
      if (v.gnt) data_req = 0; else inst_req = 0;
      mem_addr_ok = (c == v.stall);
      @(negedge clk);
      f = sb[0];
      chk("addr_mem_req", mem_req, 1);
      chk("addr_mem_wr", mem_wr, f.wr);
      chk("addr_mem_size", mem_size, f.size);
      chk("addr_mem_addr", mem_addr, f.addr);
      chk("addr_mem_wstrb", mem_wstrb, f.wstrb);
      chk("addr_mem_wdata", mem_wdata, f.wdata);
      chk("addr_no_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
      chk("addr_no_data_ok", {inst_data_ok, data_data_ok}, 0);
    end
    @(posedge clk); #1;
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = v.rdata;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      f = sb.pop_front();
      chk("data_mem_req", mem_req, 0);
      chk("inst_data_ok", inst_data_ok, !f.gnt);
      chk("data_data_ok", data_data_ok, f.gnt);
      chk("resp_rdata", f.gnt ? data_rdata : inst_rdata, f.rdata);
      chk("data_no_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    end
    @(posedge clk); #1;
    mem_data_ok = 0; inst_req = 0; data_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rr_tie;
`ifdef ARB_ROUND_ROBIN_EN
    rr_tie = 1'b0;
`else
    rr_tie = 1'b1;
`endif
    vecs[0] = mk(1, 0, 2, 32'hBFC0_0000, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3C08_0001, 0);
    vecs[1] = mk(1, 0, 2, 32'h100, 4'h0, 0, 1, 1, 2, 32'h200, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 1);
    vecs[2] = mk(1, 0, 2, 32'h100, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h203, 4'h8, 32'hAA00_0000, 4, 32'h0, 1);
    vecs[4] = mk(1, 0, 2, 32'h300, 4'h0, 0, 1, 0, 2, 32'h400, 4'h0, 0, 1, 32'h5555_AAAA, rr_tie);
    vecs[5] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h404, 4'h0, 0, 2, 32'h0000_BEEF, 1);

    idle_inputs();
    resetn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_fields", {mem_wr, mem_size, mem_wstrb}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    resetn = 1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Asynchronous reset while a response is pending in DATA.
    @(posedge clk); #1;
    inst_req = 1; inst_addr = 32'h500; inst_size = 2;
    @(negedge clk);
    chk("rstseq_addr_ok", inst_addr_ok, 1);
    @(posedge clk); #1;
    inst_req = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("rstseq_mem_req", mem_req, 1);
    @(posedge clk); #1;
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hFFFF_0000;
    #1;
    chk("rstseq_in_data", inst_data_ok, 1);
    #1;
    resetn = 0; data_req = 1;
    #1;
    chk("rstseq_mem_req0", mem_req, 0);
    chk("rstseq_mem_addr0", mem_addr, 0);
    chk("rstseq_fields0", {mem_wr, mem_size, mem_wstrb}, 0);
    chk("rstseq_oks0", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    @(negedge clk);
    data_req = 0; resetn = 1;
    @(negedge clk);
    chk("rstseq_late_resp", {inst_data_ok, data_data_ok}, 0);
    chk("rstseq_idle", mem_req, 0);
    @(posedge clk); #1;
    mem_data_ok = 0;
    run_txn(mk(1, 0, 2, 32'h504, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 0));

    // Spurious memory handshakes in IDLE.
    @(posedge clk); #1;
    mem_addr_ok = 1;
    @(negedge clk);
    chk("spur_addr_mem_req", mem_req, 0);
    @(posedge clk); #1;
    mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("spur_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("spur_mem_req", mem_req, 0);
    @(posedge clk); #1;
    mem_data_ok = 0;
    run_txn(mk(1, 0, 1, 32'h508, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1357, 0));

    // Tie with inst last granted: data first, inst accepted exactly 3 cycles later.
    @(posedge clk); #1;
    inst_req = 1; inst_wr = 0; inst_addr = 32'h600; inst_size = 2;
    data_req = 1; data_wr = 1; data_addr = 32'h700; data_size = 1; data_wstrb = 4'h3; data_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("tie_data_win", data_addr_ok, 1);
    chk("tie_inst_wait", inst_addr_ok, 0);
    @(posedge clk); #1;
    data_req = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("tie_mem_addr", mem_addr, 32'h700);
    chk("tie_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("tie_c1_inst_ok", inst_addr_ok, 0);
    @(posedge clk); #1;
    mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("tie_data_resp", data_data_ok, 1);
    chk("tie_c2_inst_ok", inst_addr_ok, 0);
    @(posedge clk); #1;
    mem_data_ok = 0;
    @(negedge clk);
    chk("tie_c3_inst_ok", inst_addr_ok, 1);
    @(posedge clk); #1;
    inst_req = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("tie_inst_mem_addr", mem_addr, 32'h600);
    chk("tie_inst_mem_wr", mem_wr, 0);
    @(posedge clk); #1;
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h2468_ACE0;
    @(negedge clk);
    chk("tie_inst_resp", inst_data_ok, 1);
    chk("tie_inst_rdata", inst_rdata, 32'h2468_ACE0);
    chk("tie_no_data_resp", data_data_ok, 0);
    @(posedge clk); #1;
    mem_data_ok = 0;

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
